// File: rtl/multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// multi_timer_pkg : register map, CTRL bit positions and limits for multi_timer
// Revision: 1.0
// ============================================================================
package multi_timer_pkg;

   localparam int NUM_CH_MIN = 1;
   localparam int NUM_CH_MAX = 8;
   localparam int WIDTH_MIN  = 8;
   localparam int WIDTH_MAX  = 32;

   typedef enum logic [1:0] {
      REG_CTRL    = 2'd0,
      REG_COMPARE = 2'd1,
      REG_COUNT   = 2'd2,
      REG_RSVD    = 2'd3
   } chan_reg_e;

   localparam logic [4:0] GLB_PENDING  = 5'd0;
   localparam logic [4:0] GLB_PRESCALE = 5'd1;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQEN    = 2;
   localparam int CTRL_CLR      = 3;

   localparam int PRESCALE_W = 16;

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_timer_channel.sv
`default_nettype none
// ============================================================================
// timer_channel : one counter/compare channel with CTRL bits and match pulse
// Revision: 1.0
// ============================================================================
module timer_channel
   import multi_timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             input_clk,
   input  logic             reset,
   input  logic             tick_i,
   input  logic             ctrl_we_i,
   input  logic             cmp_we_i,
   input  logic             cnt_we_i,
   input  logic [3:0]       we_i,
   input  logic [31:0]      wdata_i,
   output logic [WIDTH-1:0] count_o,
   output logic [WIDTH-1:0] compare_o,
   output logic [2:0]       ctrl_o,
   output logic             match_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] compare_q, compare_d;
   logic             en_q, en_d;
   logic             periodic_q, periodic_d;
   logic             irqen_q, irqen_d;
   logic [31:0]      w_cnt_merge;
   logic [31:0]      w_cmp_merge;
   logic             w_clr;
   logic             w_cpu_load;

   assign w_cnt_merge = byte_merge(32'(count_q), wdata_i, we_i);
   assign w_cmp_merge = byte_merge(32'(compare_q), wdata_i, we_i);
   assign w_clr       = ctrl_we_i & wdata_i[CTRL_CLR];
   assign w_cpu_load  = cnt_we_i | w_clr;

   always_comb begin
      count_d    = count_q;
      compare_d  = compare_q;
      en_d       = en_q;
      periodic_d = periodic_q;
      irqen_d    = irqen_q;
      match_o    = 1'b0;

      if (cmp_we_i) compare_d = w_cmp_merge[WIDTH-1:0];

      // A CPU load of COUNT suppresses both increment and match this cycle.
      if (w_cpu_load) begin
         count_d = w_clr ? '0 : w_cnt_merge[WIDTH-1:0];
      end else if (tick_i && en_q) begin
         if (count_q == compare_q) begin
            match_o = 1'b1;
            if (periodic_q) count_d = '0;
            else            en_d    = 1'b0;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end

      if (ctrl_we_i) begin
         en_d       = wdata_i[CTRL_EN];
         periodic_d = wdata_i[CTRL_PERIODIC];
         irqen_d    = wdata_i[CTRL_IRQEN];
      end
   end

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         compare_q  <= '1;
         en_q       <= 1'b0;
         periodic_q <= 1'b0;
         irqen_q    <= 1'b0;
      end else begin
         count_q    <= count_d;
         compare_q  <= compare_d;
         en_q       <= en_d;
         periodic_q <= periodic_d;
         irqen_q    <= irqen_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ctrl_o    = {irqen_q, periodic_q, en_q};

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// multi_timer : NUM_CH compare timers with bus decode, PENDING, read mux.
// Optional shared prescaler enabled by MULTI_TIMER_PRESCALE_EN.
// Revision: 1.0
// ============================================================================
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 32
) (
   input  logic              input_clk,
   input  logic              reset,
   input  logic              select,
   input  logic [3:0]        we,
   input  logic [5:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [NUM_CH-1:0] irq_vec,
   output logic              interrupt
);

   logic              w_wr;
   logic              w_glb;
   logic              w_tick;
   chan_reg_e         w_reg;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] w_match;
   logic [NUM_CH-1:0] w_irqen;
   logic [NUM_CH-1:0] w_w1c;
   logic [31:0]       w_chan_rd [NUM_CH];

   assign w_wr  = select & (|we);
   assign w_glb = addr[5];
   assign w_reg = chan_reg_e'(addr[1:0]);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic             w_hit;
      logic [WIDTH-1:0] w_count;
      logic [WIDTH-1:0] w_compare;
      logic [2:0]       w_ctrl;
      logic [31:0]      w_rd;

      assign w_hit = w_wr & ~w_glb & (addr[4:2] == 3'(i));

      timer_channel #(
         .WIDTH (WIDTH)
      ) u_chan (
         .input_clk (input_clk),
         .reset     (reset),
         .tick_i    (w_tick),
         .ctrl_we_i (w_hit & (w_reg == REG_CTRL) & we[0]),
         .cmp_we_i  (w_hit & (w_reg == REG_COMPARE)),
         .cnt_we_i  (w_hit & (w_reg == REG_COUNT)),
         .we_i      (we),
         .wdata_i   (wdata),
         .count_o   (w_count),
         .compare_o (w_compare),
         .ctrl_o    (w_ctrl),
         .match_o   (w_match[i])
      );

      assign w_irqen[i] = w_ctrl[CTRL_IRQEN];

      always_comb begin
         w_rd = '0;
         case (w_reg)
            REG_CTRL:    w_rd[2:0]       = w_ctrl;
            REG_COMPARE: w_rd[WIDTH-1:0] = w_compare;
            REG_COUNT:   w_rd[WIDTH-1:0] = w_count;
            default:     w_rd            = '0;
         endcase
      end

      assign w_chan_rd[i] = w_rd;
   end

   // A match in the same cycle as a W1C keeps the bit set.
   assign w_w1c     = (w_wr & w_glb & (addr[4:0] == GLB_PENDING) & we[0]) ?
                      wdata[NUM_CH-1:0] : '0;
   assign pending_d = (pending_q & ~w_w1c) | w_match;

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign irq_vec   = pending_q & w_irqen;
   assign interrupt = |irq_vec;

`ifdef MULTI_TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] pscnt_q, pscnt_d;
   logic                  w_ps_we;

   assign w_ps_we = w_wr & w_glb & (addr[4:0] == GLB_PRESCALE) & (|we[1:0]);
   assign w_tick  = (pscnt_q == prescale_q);

   always_comb begin
      prescale_d = prescale_q;
      pscnt_d    = pscnt_q + PRESCALE_W'(1);
      if (w_ps_we) begin
         if (we[0]) prescale_d[7:0]  = wdata[7:0];
         if (we[1]) prescale_d[15:8] = wdata[15:8];
         pscnt_d = '0;
      end else if (pscnt_q == prescale_q) begin
         pscnt_d = '0;
      end
   end

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         prescale_q <= '0;
         pscnt_q    <= '0;
      end else begin
         prescale_q <= prescale_d;
         pscnt_q    <= pscnt_d;
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   always_comb begin
      rdata = '0;
      if (!w_glb) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (addr[4:2] == 3'(i)) rdata = w_chan_rd[i];
         end
      end else begin
         case (addr[4:0])
            GLB_PENDING:  rdata[NUM_CH-1:0] = pending_q;
`ifdef MULTI_TIMER_PRESCALE_EN
            GLB_PRESCALE: rdata[PRESCALE_W-1:0] = prescale_q;
`endif
            default:      rdata = '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// Directed bench for multi_timer: hand-computed expectations per scenario.
module tb_multi_timer;

   logic        input_clk = 1'b0;
   logic        reset     = 1'b1;
   logic        select    = 1'b0;
   logic [3:0]  we        = 4'h0;
   logic [5:0]  addr      = 6'h0;
   logic [31:0] wdata     = 32'h0;
   logic [31:0] rdata;
   logic [3:0]  irq_vec;
   logic        interrupt;

   int total = 0;
   int bad   = 0;

   localparam logic [5:0] A_PEND = 6'h20;
   localparam logic [5:0] A_PSC  = 6'h21;

   always #5 input_clk = ~input_clk;

   multi_timer #(
      .NUM_CH (4),
      .WIDTH  (32)
   ) dut (
      .input_clk (input_clk),
      .reset     (reset),
      .select    (select),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .irq_vec   (irq_vec),
      .interrupt (interrupt)
   );

   function automatic logic [5:0] ca(input int ch, input int r);
      return {1'b0, 3'(ch), 2'(r)};
   endfunction

   task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge input_clk);
      select = 1'b1; addr = a; wdata = d; we = be;
      @(negedge input_clk);
      select = 1'b0; we = 4'h0;
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic test_reset();
      logic [5:0]  ra [6];
      logic [31:0] re [6];
      logic [31:0] v;
      ra = '{ca(0,0), ca(0,1), ca(0,2), A_PEND, A_PSC, ca(5,1)};
      re = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
      repeat (2) @(negedge input_clk);
      for (int i = 0; i < 6; i++) begin
         rd(ra[i], v);
         total++;
         if (v !== re[i]) begin
            bad++; $display("FAIL reset_read[%0d]: got %h want %h", i, v, re[i]);
         end
      end
      total++;
      if (irq_vec !== 4'h0 || interrupt !== 1'b0) begin
         bad++; $display("FAIL reset_irq: got %b/%b want 0000/0", irq_vec, interrupt);
      end
      @(negedge input_clk);
      reset = 1'b0;
   endtask

   task automatic test_periodic();
      logic [31:0] v, p;
      wr(ca(0,1), 32'd4, 4'hF);
      wr(ca(0,0), 32'h7, 4'h1);
      rd(ca(0,2), v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL per_count0: got %h want 0", v); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge input_clk);
         rd(ca(0,2), v);
         rd(A_PEND, p);
         total++;
         if (v !== ((k == 5) ? 32'd0 : 32'(k))) begin
            bad++; $display("FAIL per_count[%0d]: got %h", k, v);
         end
         total++;
         if (p[0] !== (k == 5) || interrupt !== (k == 5)) begin
            bad++; $display("FAIL per_pend[%0d]: got %b/%b want %b", k, p[0], interrupt, (k == 5));
         end
      end
      select = 1'b1; addr = A_PEND; wdata = 32'h1; we = 4'h1;
      @(negedge input_clk);
      select = 1'b0; we = 4'h0;
      rd(A_PEND, p);
      rd(ca(0,2), v);
      total++;
      if (p !== 32'h0 || interrupt !== 1'b0 || v !== 32'd1) begin
         bad++; $display("FAIL per_w1c: got pend %h irq %b cnt %h want 0/0/1", p, interrupt, v);
      end
   endtask

   task automatic test_w1c_collision();
      logic [31:0] v, p;
      repeat (3) @(negedge input_clk);
      rd(ca(0,2), v);
      total++;
      if (v !== 32'd4) begin bad++; $display("FAIL col_pre: got %h want 4", v); end
      select = 1'b1; addr = A_PEND; wdata = 32'h1; we = 4'h1;
      @(negedge input_clk);
      select = 1'b0; we = 4'h0;
      rd(A_PEND, p);
      rd(ca(0,2), v);
      total++;
      if (p[0] !== 1'b1 || interrupt !== 1'b1 || v !== 32'd0) begin
         bad++; $display("FAIL col_setwins: got pend %b irq %b cnt %h want 1/1/0", p[0], interrupt, v);
      end
      select = 1'b1; addr = A_PEND; wdata = 32'h1; we = 4'h1;
      @(negedge input_clk);
      select = 1'b0; we = 4'h0;
      rd(A_PEND, p);
      rd(ca(0,2), v);
      total++;
      if (p !== 32'h0 || v !== 32'd1) begin
         bad++; $display("FAIL col_clear: got pend %h cnt %h want 0/1", p, v);
      end
      wr(ca(0,0), 32'h8, 4'h1);
      repeat (2) @(negedge input_clk);
      rd(ca(0,2), v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL clr_freeze: got %h want 0", v); end
   endtask

   task automatic test_oneshot();
      logic [31:0] v, p;
      wr(ca(1,1), 32'd2, 4'hF);
      wr(ca(1,0), 32'h5, 4'h1);
      repeat (6) @(negedge input_clk);
      rd(ca(1,2), v);
      total++;
      if (v !== 32'd2) begin bad++; $display("FAIL os_count: got %h want 2", v); end
      rd(ca(1,0), v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL os_ctrl: got %h want 4", v); end
      rd(A_PEND, p);
      total++;
      if (p !== 32'h2 || irq_vec !== 4'h2) begin
         bad++; $display("FAIL os_pend: got %h/%b want 2/0010", p, irq_vec);
      end
      wr(A_PEND, 32'h2, 4'h1);
      repeat (5) @(negedge input_clk);
      rd(A_PEND, p);
      rd(ca(1,2), v);
      total++;
      if (p !== 32'h0 || v !== 32'd2) begin
         bad++; $display("FAIL os_single: got pend %h cnt %h want 0/2", p, v);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] v, p;
      int seen, t_prev, period, exp_psc, exp_period;
`ifdef MULTI_TIMER_PRESCALE_EN
      exp_psc = 3; exp_period = 8;
`else
      exp_psc = 0; exp_period = 2;
`endif
      seen = 0; t_prev = 0; period = 0;
      wr(A_PSC, 32'h3, 4'b0011);
      rd(A_PSC, v);
      total++;
      if (v !== 32'(exp_psc)) begin bad++; $display("FAIL psc_read: got %h want %0d", v, exp_psc); end
      wr(ca(0,1), 32'd1, 4'hF);
      wr(ca(0,0), 32'h3, 4'h1);
      for (int cyc = 0; cyc < 80 && seen < 3; cyc++) begin
         @(negedge input_clk);
         select = 1'b0; we = 4'h0;
         rd(A_PEND, p);
         if (p[0]) begin
            seen++;
            if (seen == 3) period = cyc - t_prev;
            t_prev = cyc;
            addr = A_PEND; wdata = 32'h1; we = 4'h1; select = 1'b1;
         end
      end
      @(negedge input_clk);
      select = 1'b0; we = 4'h0;
      total++;
      if (seen < 3 || period != exp_period) begin
         bad++; $display("FAIL psc_period: got %0d (seen %0d) want %0d", period, seen, exp_period);
      end
      wr(ca(0,0), 32'h8, 4'h1);
      wr(A_PSC, 32'h0, 4'b0011);
      wr(A_PEND, 32'hF, 4'h1);
   endtask

   task automatic test_wrap();
      logic [31:0] v, p;
      logic [31:0] exp_c [4];
      exp_c = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1};
      wr(ca(2,1), 32'd1, 4'hF);
      wr(ca(2,2), 32'hFFFF_FFFE, 4'hF);
      wr(ca(2,0), 32'h1, 4'h1);
      rd(ca(2,2), v);
      total++;
      if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_load: got %h want fffffffe", v); end
      for (int k = 0; k < 4; k++) begin
         @(negedge input_clk);
         rd(ca(2,2), v);
         total++;
         if (v !== exp_c[k]) begin bad++; $display("FAIL wrap_count[%0d]: got %h want %h", k, v, exp_c[k]); end
      end
      rd(A_PEND, p);
      total++;
      if (p !== 32'h4 || irq_vec !== 4'h0 || interrupt !== 1'b0) begin
         bad++; $display("FAIL wrap_pend: got %h/%b/%b want 4/0000/0", p, irq_vec, interrupt);
      end
   endtask

   task automatic test_irqen();
      logic [31:0] v;
      wr(ca(2,0), 32'h4, 4'h1);
      total++;
      if (irq_vec !== 4'h4 || interrupt !== 1'b1) begin
         bad++; $display("FAIL irqen_late: got %b/%b want 0100/1", irq_vec, interrupt);
      end
      rd(ca(2,0), v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL irqen_ctrl: got %h want 4", v); end
   endtask

   task automatic test_cpu_wins();
      logic [31:0] v;
      wr(ca(3,0), 32'h1, 4'h1);
      repeat (3) @(negedge input_clk);
      wr(ca(3,2), 32'h100, 4'hF);
      rd(ca(3,2), v);
      total++;
      if (v !== 32'h100) begin bad++; $display("FAIL cpu_load: got %h want 100", v); end
      @(negedge input_clk);
      rd(ca(3,2), v);
      total++;
      if (v !== 32'h101) begin bad++; $display("FAIL cpu_next: got %h want 101", v); end
      wr(ca(3,1), 32'h00AB_0000, 4'b0100);
      rd(ca(3,1), v);
      total++;
      if (v !== 32'hFFAB_FFFF) begin bad++; $display("FAIL cmp_lane: got %h want ffabffff", v); end
      wr(ca(3,0), 32'h9, 4'h1);
      rd(ca(3,2), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL clr_load: got %h want 0", v); end
      rd(ca(3,0), v);
      total++;
      if (v !== 32'h1) begin bad++; $display("FAIL clr_ctrl: got %h want 1", v); end
      wr(ca(3,3), 32'hDEAD_BEEF, 4'hF);
      rd(ca(3,3), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL rsvd: got %h want 0", v); end
      wr(ca(3,0), 32'h0, 4'h1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      logic [5:0]  ra [5];
      logic [31:0] re [5];
      ra = '{ca(0,0), ca(0,1), ca(0,2), A_PEND, ca(2,0)};
      re = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
      total++;
      if (interrupt !== 1'b1) begin bad++; $display("FAIL rst_pre: got %b want 1", interrupt); end
      wr(ca(0,1), 32'd3, 4'hF);
      wr(ca(0,0), 32'h7, 4'h1);
      @(negedge input_clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if (interrupt !== 1'b0 || irq_vec !== 4'h0) begin
         bad++; $display("FAIL rst_irq: got %b/%b want 0/0000", interrupt, irq_vec);
      end
      for (int i = 0; i < 5; i++) begin
         rd(ra[i], v);
         total++;
         if (v !== re[i]) begin bad++; $display("FAIL rst_mid[%0d]: got %h want %h", i, v, re[i]); end
      end
      repeat (2) @(negedge input_clk);
      reset = 1'b0;
      repeat (8) @(negedge input_clk);
      rd(A_PEND, v);
      total++;
      if (v !== 32'h0 || interrupt !== 1'b0) begin
         bad++; $display("FAIL rst_release: got %h/%b want 0/0", v, interrupt);
      end
      rd(ca(0,2), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL rst_count: got %h want 0", v); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_periodic();
      test_w1c_collision();
      test_oneshot();
      test_prescale();
      test_wrap();
      test_irqen();
      test_cpu_wins();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
